// File: rtl/cpu_core.sv
// 16-bit multi-cycle CPU: unified word memory, 8x16 register file, one instruction per CLKS_PER_INSTR clocks.
// Optional multiplier for opcode E is enabled by defining MUL_EN; otherwise opcode E executes as a NOP.
module cpu_core #(
  parameter int unsigned CLKS_PER_INSTR = 64,
  parameter int unsigned MEM_WORDS      = 1024
) (
  input  logic       CLK_50,
  input  logic       KEY0,
  output logic [9:0] LEDR,
  output logic       LED_HLT
);
  localparam int unsigned CW = $clog2(CLKS_PER_INSTR);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [3:0] {
    OP_HALT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_XOR = 4'h5, OP_SLT = 4'h6, OP_ADDI = 4'h7,
    OP_LI   = 4'h8, OP_LUI = 4'h9, OP_BEQ = 4'hA, OP_J    = 4'hB,
    OP_LW   = 4'hC, OP_SW  = 4'hD, OP_MUL = 4'hE, OP_NOP  = 4'hF
  } opcode_e;

  logic [15:0]   mem      [0:MEM_WORDS-1];
  logic [15:0]   reg_file [0:7];
  logic [15:0]   pc;
  logic          halted;
  logic [CW-1:0] r_cnt;

  logic [15:0]   w_instr;
  opcode_e       w_op;
  logic [2:0]    w_fa, w_fb, w_fc;
  logic [15:0]   w_ra, w_rb, w_rc, w_imm6, w_imm9;
  logic [AW-1:0] w_addr;
  logic          w_commit;
  logic          w_we, w_mem_we;
  logic [15:0]   w_wdata, w_pc_next;

  assign w_instr  = mem[pc[AW-1:0]];
  assign w_op     = opcode_e'(w_instr[15:12]);
  assign w_fa     = w_instr[11:9];
  assign w_fb     = w_instr[8:6];
  assign w_fc     = w_instr[5:3];
  assign w_ra     = reg_file[w_fa];
  assign w_rb     = reg_file[w_fb];
  assign w_rc     = reg_file[w_fc];
  assign w_imm6   = {{10{w_instr[5]}}, w_instr[5:0]};
  assign w_imm9   = {{7{w_instr[8]}}, w_instr[8:0]};
  assign w_addr   = AW'(w_rb + w_imm6);
  assign halted   = (w_op == OP_HALT);
  assign w_commit = (r_cnt == '1);
  assign LEDR     = reg_file[1][9:0];
  assign LED_HLT  = halted;

  always_comb begin
    w_we      = 1'b0;
    w_mem_we  = 1'b0;
    w_wdata   = '0;
    w_pc_next = pc + 16'd1;
    case (w_op)
      OP_ADD:  begin w_we = 1'b1; w_wdata = w_rb + w_rc; end
      OP_SUB:  begin w_we = 1'b1; w_wdata = w_rb - w_rc; end
      OP_AND:  begin w_we = 1'b1; w_wdata = w_rb & w_rc; end
      OP_OR:   begin w_we = 1'b1; w_wdata = w_rb | w_rc; end
      OP_XOR:  begin w_we = 1'b1; w_wdata = w_rb ^ w_rc; end
      OP_SLT:  begin w_we = 1'b1; w_wdata = {15'd0, ($signed(w_rb) < $signed(w_rc))}; end
      OP_ADDI: begin w_we = 1'b1; w_wdata = w_rb + w_imm6; end
      OP_LI:   begin w_we = 1'b1; w_wdata = w_imm9; end
      OP_LUI:  begin w_we = 1'b1; w_wdata = {w_instr[7:0], w_ra[7:0]}; end
      OP_BEQ:  if (w_ra == w_rb) w_pc_next = pc + 16'd1 + w_imm6;
      OP_J:    w_pc_next = {pc[15:12], w_instr[11:0]};
      OP_LW:   begin w_we = 1'b1; w_wdata = mem[w_addr]; end
      OP_SW:   w_mem_we = 1'b1;
`ifdef MUL_EN
      OP_MUL:  begin w_we = 1'b1; w_wdata = w_rb * w_rc; end
`endif
      default: ;
    endcase
  end

  // Counter free-runs even while halted; commit edges simply have no effect then.
  always_ff @(posedge CLK_50 or negedge KEY0) begin
    if (!KEY0) begin
      pc    <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < 8; i++) reg_file[i] <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      if (w_commit && !halted) begin
        pc <= w_pc_next;
        if (w_we && (w_fa != 3'd0)) reg_file[w_fa] <= w_wdata;
      end
    end
  end

  // Memory is not reset; KEY0 gating drops a store interrupted by reset.
  always_ff @(posedge CLK_50) begin
    if (KEY0 && w_commit && w_mem_we) mem[w_addr] <= w_ra;
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: programs are written into memory during reset, then stepped per instruction.
module tb_cpu_core;
  localparam int STEP = 64;

  logic       CLK_50;
  logic       KEY0;
  logic [9:0] LEDR;
  logic       LED_HLT;

  int checks = 0;
  int errors = 0;
  logic [15:0] prog [0:31];

  cpu_core #(.CLKS_PER_INSTR(STEP), .MEM_WORDS(1024)) dut (
    .CLK_50 (CLK_50),
    .KEY0   (KEY0),
    .LEDR   (LEDR),
    .LED_HLT(LED_HLT)
  );

  initial CLK_50 = 1'b0;
  always #10 CLK_50 = ~CLK_50;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] a, b, c);
    return {op, a, b, c, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] a, b, input logic [5:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [15:0] enc_li(input logic [2:0] a, input logic [8:0] imm);
    return {4'h8, a, imm};
  endfunction

  task clr_prog();
    for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
  endtask

  task load_prog();
    KEY0 = 1'b0;
    @(negedge CLK_50);
    for (int i = 0; i < 1024; i++) dut.mem[i] = 16'h0000;
    for (int i = 0; i < 32; i++) dut.mem[i] = prog[i];
    @(negedge CLK_50);
    KEY0 = 1'b1;
  endtask

  task step(input int n);
    repeat (n * STEP) @(posedge CLK_50);
    @(negedge CLK_50);
  endtask

  task chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task test_reset();
    KEY0 = 1'b0;
    @(negedge CLK_50);
    checks++;
    if (dut.pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", dut.pc); end
    checks++;
    if (LEDR !== 10'd0) begin errors++; $display("FAIL reset_ledr: got %h expected 000", LEDR); end
  endtask

  task test_halt();
    clr_prog();
    load_prog();
    checks++;
    if (LED_HLT !== 1'b1) begin errors++; $display("FAIL halt_load: got %b expected 1", LED_HLT); end
    step(1);
    chk16("halt_pc", dut.pc, 16'h0000);
    checks++;
    if (dut.halted !== 1'b1) begin errors++; $display("FAIL halt_step: got %b expected 1", dut.halted); end
  endtask

  task test_addi_seq();
    logic [15:0] exp_pc [0:3];
    logic [15:0] exp_r1 [0:3];
    exp_pc = '{16'd1, 16'd2, 16'd3, 16'd4};
    exp_r1 = '{16'h0001, 16'h0001, 16'h0002, 16'hFFE2};
    clr_prog();
    prog[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd1);
    prog[1] = enc_r(4'h1, 3'd1, 3'd1, 3'd0);
    prog[2] = enc_r(4'h1, 3'd1, 3'd1, 3'd1);
    prog[3] = enc_i(4'h7, 3'd1, 3'd0, 6'b100010);
    prog[4] = enc_i(4'h7, 3'd1, 3'd0, 6'd1);
    load_prog();
    checks++;
    if (LED_HLT !== 1'b0) begin errors++; $display("FAIL seq_run: got %b expected 0", LED_HLT); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk16($sformatf("seq_pc%0d", i), dut.pc, exp_pc[i]);
      chk16($sformatf("seq_r1_%0d", i), dut.reg_file[1], exp_r1[i]);
    end
    checks++;
    if (LEDR !== 10'h3E2) begin errors++; $display("FAIL seq_ledr: got %h expected 3e2", LEDR); end
    step(1);
    chk16("seq_r1_end", dut.reg_file[1], 16'h0001);
    checks++;
    if (LED_HLT !== 1'b1) begin errors++; $display("FAIL seq_halt: got %b expected 1", LED_HLT); end
  endtask

  task test_branch();
    clr_prog();
    prog[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd7);
    prog[1] = enc_i(4'h7, 3'd2, 3'd0, 6'd5);
    prog[2] = enc_i(4'hA, 3'd1, 3'd2, 6'd1);
    prog[3] = enc_i(4'h7, 3'd1, 3'd1, 6'd1);
    prog[4] = enc_i(4'hA, 3'd2, 3'd2, 6'd1);
    prog[5] = enc_i(4'h7, 3'd2, 3'd0, 6'd9);
    prog[6] = enc_i(4'h7, 3'd0, 3'd0, 6'd3);
    load_prog();
    step(3);
    chk16("beq_not_taken_pc", dut.pc, 16'd3);
    step(2);
    chk16("beq_taken_pc", dut.pc, 16'd6);
    step(1);
    chk16("beq_end_pc", dut.pc, 16'd7);
    chk16("beq_r1", dut.reg_file[1], 16'd8);
    chk16("beq_r2", dut.reg_file[2], 16'd5);
    chk16("beq_r0", dut.reg_file[0], 16'd0);
  endtask

  task test_jump();
    clr_prog();
    prog[0] = 16'hB002;
    prog[1] = enc_i(4'h7, 3'd1, 3'd0, 6'd5);
    prog[2] = enc_i(4'h7, 3'd1, 3'd0, 6'd1);
    load_prog();
    step(1);
    chk16("j_pc", dut.pc, 16'd2);
    step(1);
    chk16("j_r1", dut.reg_file[1], 16'd1);
    chk16("j_end_pc", dut.pc, 16'd3);
  endtask

  task test_mem();
    clr_prog();
    prog[0]  = enc_i(4'hC, 3'd1, 3'd0, 6'd30);
    prog[1]  = enc_i(4'h7, 3'd2, 3'd1, 6'd1);
    prog[2]  = enc_i(4'hD, 3'd2, 3'd0, 6'd31);
    prog[30] = 16'h6001;
    load_prog();
    step(3);
    chk16("lw_r1", dut.reg_file[1], 16'h6001);
    chk16("sw_mem31", dut.mem[31], 16'h6002);
    chk16("mem_pc", dut.pc, 16'd3);
  endtask

  task test_alu();
    clr_prog();
    prog[0] = enc_li(3'd1, 9'h1FD);
    prog[1] = enc_li(3'd2, 9'h005);
    prog[2] = enc_r(4'h6, 3'd3, 3'd1, 3'd2);
    prog[3] = enc_r(4'h2, 3'd4, 3'd2, 3'd1);
    prog[4] = enc_r(4'h5, 3'd5, 3'd1, 3'd2);
    prog[5] = enc_r(4'h3, 3'd6, 3'd1, 3'd2);
    prog[6] = enc_r(4'h4, 3'd7, 3'd1, 3'd2);
    prog[7] = {4'h9, 3'd2, 1'b0, 8'hAB};
    prog[8] = 16'hF000;
    prog[9] = enc_r(4'hE, 3'd3, 3'd1, 3'd1);
    load_prog();
    step(10);
    chk16("li_neg", dut.reg_file[1], 16'hFFFD);
    chk16("lui", dut.reg_file[2], 16'hAB05);
`ifdef MUL_EN
    chk16("slt_mul", dut.reg_file[3], 16'h0009);
`else
    chk16("slt_nomul", dut.reg_file[3], 16'h0001);
`endif
    chk16("sub", dut.reg_file[4], 16'h0008);
    chk16("xor", dut.reg_file[5], 16'hFFF8);
    chk16("and", dut.reg_file[6], 16'h0005);
    chk16("or", dut.reg_file[7], 16'hFFFD);
    chk16("alu_pc", dut.pc, 16'd10);
  endtask

  task test_reset_mid();
    clr_prog();
    prog[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd5);
    prog[1] = enc_i(4'h7, 3'd1, 3'd0, 6'd1);
    load_prog();
    step(1);
    checks++;
    if (LEDR !== 10'd5) begin errors++; $display("FAIL mid_pre_ledr: got %h expected 005", LEDR); end
    repeat (30) @(posedge CLK_50);
    #3 KEY0 = 1'b0;
    #1;
    chk16("mid_pc", dut.pc, 16'd0);
    chk16("mid_r1", dut.reg_file[1], 16'd0);
    checks++;
    if (LEDR !== 10'd0) begin errors++; $display("FAIL mid_ledr: got %h expected 000", LEDR); end
  endtask

  task test_mul();
    clr_prog();
    prog[0] = enc_li(3'd1, 9'd3);
    prog[1] = enc_li(3'd2, 9'h1FE);
    prog[2] = enc_r(4'hE, 3'd3, 3'd1, 3'd2);
    load_prog();
    step(3);
`ifdef MUL_EN
    chk16("mul", dut.reg_file[3], 16'hFFFA);
`else
    chk16("mul_nop", dut.reg_file[3], 16'h0000);
`endif
    chk16("mul_pc", dut.pc, 16'd3);
  endtask

  initial begin
    KEY0 = 1'b0;
    test_reset();
    test_halt();
    test_addi_seq();
    test_branch();
    test_jump();
    test_mem();
    test_alu();
    test_reset_mid();
    test_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
